// File: rtl/a2d_pkg.sv
// Shared channel and main-FSM definitions for the A2D interface.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package a2d_pkg;

    typedef enum logic [1:0] {LFT, RGHT, BATT} chnl_t;

    localparam logic [2:0] LFT_CODE  = 3'd0;
    localparam logic [2:0] RGHT_CODE = 3'd4;
    localparam logic [2:0] BATT_CODE = 3'd5;

    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, UPD} state_t;

    function automatic logic [2:0] chnl_code(input chnl_t c);
        case (c)
            RGHT:    chnl_code = RGHT_CODE;
            BATT:    chnl_code = BATT_CODE;
            default: chnl_code = LFT_CODE;
        endcase
    endfunction

    function automatic chnl_t chnl_next(input chnl_t c);
        case (c)
            LFT:     chnl_next = RGHT;
            RGHT:    chnl_next = BATT;
            default: chnl_next = LFT;
        endcase
    endfunction

    function automatic logic [15:0] cmd_word(input chnl_t c);
        cmd_word = {2'b00, chnl_code(c), 11'h000};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// 16-bit SPI master, mode 3 (SCLK idle high, MOSI changes on fall, MISO sampled on rise).
// Latency: half-period front porch + 16 SCLK periods + half-period back porch; done pulses as SS_n rises.
// Backpressure: wrt is only honoured while idle; requests arriving mid-transfer are dropped.
module spi_mstr16 #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    typedef enum logic [1:0] {SPI_IDLE, FRONT, SHIFT, BACK} spi_state_t;

    localparam int                    HALF      = 1 << (SCLK_DIV_W - 1);
    localparam logic [SCLK_DIV_W-1:0] HALF_LAST = SCLK_DIV_W'(HALF - 1);
    localparam logic [SCLK_DIV_W-1:0] FULL_LAST = '1;
    localparam logic [SCLK_DIV_W-1:0] DIV_ONE   = SCLK_DIV_W'(1);

    spi_state_t            state;
    logic [SCLK_DIV_W-1:0] div;
    logic [3:0]            bit_cnt;
    logic [15:0]           tx_shft;
    logic [15:0]           rx_shft;

    assign rd_data = rx_shft;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SPI_IDLE;
            div     <= '0;
            bit_cnt <= 4'd0;
            tx_shft <= 16'h0000;
            rx_shft <= 16'h0000;
            SS_n    <= 1'b1;
            SCLK    <= 1'b1;
            MOSI    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SPI_IDLE: begin
                    if (wrt) begin
                        SS_n    <= 1'b0;
                        div     <= '0;
                        bit_cnt <= 4'd0;
                        tx_shft <= cmd;
                        state   <= FRONT;
                    end
                end
                FRONT: begin
                    if (div == HALF_LAST) begin
                        SCLK    <= 1'b0;
                        MOSI    <= tx_shft[15];
                        tx_shft <= {tx_shft[14:0], 1'b0};
                        div     <= '0;
                        state   <= SHIFT;
                    end else begin
                        div <= div + DIV_ONE;
                    end
                end
                SHIFT: begin
                    // div wraps at FULL_LAST, giving the full SCLK period for free
                    div <= div + DIV_ONE;
                    if (div == HALF_LAST) begin
                        SCLK    <= 1'b1;
                        rx_shft <= {rx_shft[14:0], MISO};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            div   <= '0;
                            state <= BACK;
                        end
                    end else if (div == FULL_LAST) begin
                        SCLK    <= 1'b0;
                        MOSI    <= tx_shft[15];
                        tx_shft <= {tx_shft[14:0], 1'b0};
                    end
                end
                BACK: begin
                    if (div == HALF_LAST) begin
                        SS_n  <= 1'b1;
                        MOSI  <= 1'b0;
                        done  <= 1'b1;
                        state <= SPI_IDLE;
                    end else begin
                        div <= div + DIV_ONE;
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/a2d_intf.sv
// Round-robin A2D reader (lft ch0, rght ch4, batt ch5); A2D_AVG_EN enables 2-sample averaging.
// Latency: two back-to-back SPI transfers plus 3 clks from nxt to the cnv_cmplt pulse.
// Backpressure: nxt is dropped unless idle; nothing is queued.
module a2d_intf #(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    import a2d_pkg::*;

    state_t      state;
    chnl_t       chnl;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] raw;
    logic [11:0] res;
    logic        rd_unused;

    // Upper nibble of the A2D reply carries no conversion data
    assign rd_unused = ^rd_data[15:12];

    spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

`ifdef A2D_AVG_EN
    logic [11:0] prev_lft;
    logic [11:0] prev_rght;
    logic [11:0] prev_batt;
    logic [11:0] prev_sel;

    always_comb begin
        case (chnl)
            RGHT:    prev_sel = prev_rght;
            BATT:    prev_sel = prev_batt;
            default: prev_sel = prev_lft;
        endcase
        res = 12'(({1'b0, raw} + {1'b0, prev_sel}) >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_lft  <= 12'h000;
            prev_rght <= 12'h000;
            prev_batt <= 12'h000;
        end else if (state == UPD) begin
            case (chnl)
                LFT:     prev_lft  <= raw;
                RGHT:    prev_rght <= raw;
                BATT:    prev_batt <= raw;
                default: ;
            endcase
        end
    end
`else
    always_comb res = raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chnl      <= LFT;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            raw       <= 12'h000;
            cnv_cmplt <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
        end else begin
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    if (nxt) begin
                        wrt   <= 1'b1;
                        cmd   <= cmd_word(chnl);
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (done) state <= GAP;
                end
                GAP: begin
                    wrt   <= 1'b1;
                    cmd   <= 16'h0000;
                    state <= READ;
                end
                READ: begin
                    if (done) begin
                        raw   <= rd_data[11:0];
                        state <= UPD;
                    end
                end
                UPD: begin
                    case (chnl)
                        LFT:     lft_ld  <= res;
                        RGHT:    rght_ld <= res;
                        BATT:    batt    <= res;
                        default: ;
                    endcase
                    cnv_cmplt <= 1'b1;
                    chnl      <= chnl_next(chnl);
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_intf.sv
// Bench for a2d_intf: SPI slave model plus channel/result reference model.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nxt;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt;
    logic        SS_n, SCLK, MOSI, MISO;

    always #5 clk = ~clk;

    a2d_intf #(.SCLK_DIV_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .nxt(nxt),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt), .cnv_cmplt(cnv_cmplt),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- bus monitor / SPI slave ----------------
    int unsigned cyc = 0;
    int          cmplt_cnt = 0;
    always @(posedge clk) begin
        cyc++;
        if (cnv_cmplt === 1'b1) cmplt_cnt++;
    end

    logic        mon_en = 1'b0;
    logic [15:0] resp_q[$];
    logic [15:0] mosi_q[$];
    int          rise_q[$];
    int          lead_q[$];
    int          gap_q[$];
    int          starts = 0, ends = 0, xfer_rise = 0;
    int          per_bad = 0, per_cnt = 0, early_bad = 0;
    int unsigned ss_fall_cyc = 0, ss_rise_cyc = 0, last_rise_cyc = 0;
    logic        ss_prev = 1'b1, sclk_prev = 1'b1;
    logic [15:0] slv_word = 16'h0000;
    logic [15:0] mosi_sr = 16'h0000;
    logic [3:0]  miso_idx = 4'd0;

    assign MISO = slv_word[4'd15 - miso_idx];

    always @(SS_n or SCLK) begin
        if (mon_en) begin
            if (ss_prev === 1'b1 && SS_n === 1'b0) begin
                gap_q.push_back((starts == 0) ? 99 : int'(cyc - ss_rise_cyc));
                ss_fall_cyc = cyc;
                slv_word    = (starts < resp_q.size()) ? resp_q[starts] : 16'h0000;
                starts++;
                miso_idx  = 4'd0;
                mosi_sr   = 16'h0000;
                xfer_rise = 0;
            end else if (ss_prev === 1'b0 && SS_n === 1'b1) begin
                mosi_q.push_back(mosi_sr);
                rise_q.push_back(xfer_rise);
                ends++;
                ss_rise_cyc = cyc;
            end
            if (sclk_prev === 1'b0 && SCLK === 1'b1 && SS_n === 1'b0) begin
                if (xfer_rise > 0) begin
                    per_cnt++;
                    if (cyc - last_rise_cyc != 32) per_bad++;
                end
                last_rise_cyc = cyc;
                mosi_sr = {mosi_sr[14:0], MOSI};
                xfer_rise++;
            end else if (sclk_prev === 1'b1 && SCLK === 1'b0) begin
                if (SS_n !== 1'b0) early_bad++;
                if (xfer_rise == 0) lead_q.push_back(int'(cyc - ss_fall_cyc));
                miso_idx = 4'(xfer_rise);
            end
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
    end

    // ---------------- reference model ----------------
    int          m_ptr = 0;
    int          codes[3] = '{0, 4, 5};
    logic [11:0] m_out[3]  = '{12'h000, 12'h000, 12'h000};
    logic [11:0] m_prev[3] = '{12'h000, 12'h000, 12'h000};

    task automatic mdl_apply(input logic [11:0] val);
`ifdef A2D_AVG_EN
        m_out[m_ptr] = 12'((int'(val) + int'(m_prev[m_ptr])) / 2);
`else
        m_out[m_ptr] = val;
`endif
        m_prev[m_ptr] = val;
        m_ptr = (m_ptr + 1) % 3;
    endtask

    task automatic mdl_reset();
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = 12'h000;
            m_prev[i] = 12'h000;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_nxt();
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
    endtask

    task automatic wait_cmplt(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (cnv_cmplt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_lft"},  {20'h0, lft_ld},  {20'h0, m_out[0]});
        chk({tag, "_rght"}, {20'h0, rght_ld}, {20'h0, m_out[1]});
        chk({tag, "_batt"}, {20'h0, batt},    {20'h0, m_out[2]});
    endtask

    task automatic chk_xfers(input int b, input logic [15:0] exp_cmd);
        chk("xfer_count", ends - b, 2);
        if (mosi_q.size() >= b + 2 && lead_q.size() >= b + 2 && gap_q.size() >= b + 2) begin
            chk("cmd_word",   {16'h0, mosi_q[b]},     {16'h0, exp_cmd});
            chk("read_word",  {16'h0, mosi_q[b + 1]}, 32'h0);
            chk("cmd_rises",  rise_q[b],     16);
            chk("read_rises", rise_q[b + 1], 16);
            chk("cmd_lead",   lead_q[b],     16);
            chk("read_lead",  lead_q[b + 1], 16);
            chk("gap_ss_high", {31'h0, gap_q[b + 1] >= 1}, 1);
        end
    endtask

    task automatic conv_and_check(input logic [11:0] val);
        int          b;
        logic        ok;
        logic [15:0] exp_cmd;
        b = starts;
        exp_cmd = 16'(codes[m_ptr] * 2048);
        resp_q.push_back(16'($urandom));
        resp_q.push_back({4'($urandom), val});
        pulse_nxt();
        wait_cmplt(ok);
        chk("cmplt_seen", {31'h0, ok}, 1);
        mdl_apply(val);
        chk_regs("conv");
        chk_xfers(b, exp_cmd);
        @(negedge clk);
        chk("cmplt_width", {31'h0, cnv_cmplt}, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          b, bc;
        logic        ok;
        logic [11:0] v;
        logic [15:0] exp_cmd;

        rst_n = 1'b1;
        nxt   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n",  {31'h0, SS_n}, 1);
        chk("rst_sclk",  {31'h0, SCLK}, 1);
        chk("rst_mosi",  {31'h0, MOSI}, 0);
        chk("rst_cmplt", {31'h0, cnv_cmplt}, 0);
        chk_regs("rst");
        mon_en = 1'b1;
        rst_n  = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_no_start", starts, 0);

        // round robin with fixed samples
        bc = cmplt_cnt;
        conv_and_check(12'hA55);
        conv_and_check(12'h3C0);
        conv_and_check(12'h7FF);
        @(negedge clk);
        chk("rr_cmplt_cnt", cmplt_cnt - bc, 3);

        // random samples
        for (int i = 0; i < 4; i++) conv_and_check(12'($urandom_range(0, 4095)));

        // busy drop plus nxt coinciding with UPD
        b  = starts;
        bc = cmplt_cnt;
        v  = 12'($urandom_range(0, 4095));
        exp_cmd = 16'(codes[m_ptr] * 2048);
        resp_q.push_back(16'($urandom));
        resp_q.push_back({4'($urandom), v});
        pulse_nxt();
        repeat (100) @(negedge clk);
        pulse_nxt();
        repeat (300) @(negedge clk);
        pulse_nxt();
        repeat (300) @(negedge clk);
        pulse_nxt();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (ends >= b + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("busy_read_end", {31'h0, ok}, 1);
        pulse_nxt();
        chk("upd_cmplt", {31'h0, cnv_cmplt}, 1);
        mdl_apply(v);
        chk_regs("busy");
        chk_xfers(b, exp_cmd);
        repeat (1500) @(negedge clk);
        chk("busy_starts", starts - b, 2);
        chk("busy_cmplt", cmplt_cnt - bc, 1);
        conv_and_check(12'($urandom_range(0, 4095)));

        // reset mid-READ
        b = starts;
        resp_q.push_back(16'($urandom));
        resp_q.push_back({4'($urandom), 12'($urandom)});
        pulse_nxt();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (starts >= b + 2 && xfer_rise >= 8) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_read8", {31'h0, ok}, 1);
        chk_regs("pre_rst");
        rst_n = 1'b0;
        #1;
        chk("mid_ss_n",  {31'h0, SS_n}, 1);
        chk("mid_sclk",  {31'h0, SCLK}, 1);
        chk("mid_mosi",  {31'h0, MOSI}, 0);
        chk("mid_cmplt", {31'h0, cnv_cmplt}, 0);
        mdl_reset();
        chk_regs("mid_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b  = starts;
        bc = cmplt_cnt;
        repeat (1500) @(negedge clk);
        chk("post_rst_starts", starts - b, 0);
        chk("post_rst_cmplt", cmplt_cnt - bc, 0);
        chk_regs("post_rst");

        // averaging check on the left channel, starting fresh from reset
        conv_and_check(12'h100);
`ifdef A2D_AVG_EN
        chk("avg_lft_1", {20'h0, lft_ld}, 32'h080);
`else
        chk("avg_lft_1", {20'h0, lft_ld}, 32'h100);
`endif
        conv_and_check(12'($urandom_range(0, 4095)));
        conv_and_check(12'($urandom_range(0, 4095)));
        conv_and_check(12'h301);
`ifdef A2D_AVG_EN
        chk("avg_lft_2", {20'h0, lft_ld}, 32'h200);
`else
        chk("avg_lft_2", {20'h0, lft_ld}, 32'h301);
`endif

        chk("sclk_period_bad", per_bad, 0);
        chk("fall_ss_high", early_bad, 0);
        chk("periods_seen", {31'h0, per_cnt > 0}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/a2d_intf.md
A2D_INTF -- requirements
Module: a2d_intf

Interface
REQ-001 SHALL have parameter SCLK_DIV_W, default 5, giving the SCLK period as 2^SCLK_DIV_W clk cycles (32).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port nxt, input, 1, one-clk pulse requesting the next round-robin conversion (driven by the inertial INT).
REQ-005 SHALL have port lft_ld, output, 12, latest left load-cell result (channel 0).
REQ-006 SHALL have port rght_ld, output, 12, latest right load-cell result (channel 4).
REQ-007 SHALL have port batt, output, 12, latest battery result (channel 5).
REQ-008 SHALL have port cnv_cmplt, output, 1, one-clk pulse when a result register updates.
REQ-009 SHALL have port SS_n, output, 1, A2D SPI select, active low.
REQ-010 SHALL have port SCLK, output, 1, SPI clock, idle high.
REQ-011 SHALL have port MOSI, output, 1, SPI data out.
REQ-012 SHALL have port MISO, input, 1, SPI data in.

Function
REQ-013 SHALL sequence channels round-robin lft(0) -> rght(4) -> batt(5) -> lft, advancing one channel per completed conversion.
REQ-014 SHALL use a main FSM: IDLE -> CMD (nxt seen) -> GAP (CMD done) -> READ (1 clk later) -> UPD (READ done) -> IDLE (1 clk later).
REQ-015 SHALL ignore nxt in any state other than IDLE; no request is queued.
REQ-016 SHALL send in CMD the 16-bit word {2'b00, chnl[2:0], 11'h000}, MSB first, and discard the bits read back.
REQ-017 SHALL send 16'h0000 in READ and capture the result as the low 12 bits of the received word.
REQ-018 SHALL, in each transaction, drop SS_n on the clk after the start and keep SCLK high for the first 2^(SCLK_DIV_W-1) clks.
REQ-019 SHALL then run exactly 16 SCLK periods, changing MOSI on the SCLK fall and sampling MISO on the SCLK rise.
REQ-020 SHALL return SCLK high after the 16th rise and raise SS_n one half-period later.
REQ-021 SHALL hold SS_n high for at least 1 clk in GAP between the two transactions.
REQ-022 SHALL, in UPD, write only the addressed output register, pulse cnv_cmplt for exactly 1 clk, and advance the channel pointer.
REQ-023 SHALL keep the other two output registers unchanged during UPD.
REQ-024 SHALL hold lft_ld, rght_ld and batt stable at all times except the single UPD edge that writes them.
REQ-025 SHALL return to IDLE when nxt arrives in the same clk as UPD; the next nxt then starts the next channel.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-transaction, force FSM to IDLE, channel pointer to lft, SS_n=1, SCLK=1, MOSI=0, cnv_cmplt=0, and all result and filter registers to 12'h000.
REQ-027 SHALL begin in IDLE and wait for a fresh nxt after rst_n deasserts.

Configuration
REQ-028 SHALL, with macro A2D_AVG_EN defined, output each channel as ({1'b0,new}+{1'b0,prev_raw})>>1, truncated, where prev_raw is that channel's previous raw sample (reset 0).
REQ-029 SHALL, with A2D_AVG_EN undefined, output the raw 12-bit sample and contain no prev_raw storage.

Structure
REQ-030 SHALL take from shared package a2d_pkg the channel enum (LFT, RGHT, BATT), the channel code constants 3'd0, 3'd4 and 3'd5, and the main FSM state enum.
REQ-031 SHALL instantiate sub-module spi_mstr16 (wrt, cmd[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO) containing the SCLK divider, the 16-bit shift register and its own IDLE/FRONT/SHIFT/BACK FSM.

Verification
REQ-032 SHALL check reset: rst_n low -> SS_n=1, SCLK=1, all results 0, cnv_cmplt=0; nxt pulse after release -> first command word 16'h0000 (channel 0).
REQ-033 SHALL check round-robin: MISO model returns 12'hA55, 12'h3C0, 12'h7FF on three nxt pulses -> lft_ld=A55, rght_ld=3C0, batt=7FF; command words 0000, 2000, 2800; 3 cnv_cmplt pulses.
REQ-034 SHALL check SPI timing: per transaction 16 SCLK rises, 32-clk period, SS_n low before first fall, and SS_n high at least 1 clk between CMD and READ.
REQ-035 SHALL check busy drop: nxt pulsed 3 times during a conversion -> exactly one conversion and one cnv_cmplt.
REQ-036 SHALL check reset mid-op: rst_n asserted after the 8th SCLK of READ -> lines idle immediately and no output register changes.
REQ-037 SHALL check A2D_AVG_EN: lft samples 12'h100 then 12'h301 -> lft_ld 12'h080 then 12'h200; with the macro undefined -> 12'h100 then 12'h301.
